// File: rtl/swd_xfer_engine.sv
// SWD transfer engine: turns whole DP/AP commands into clocked SWD bit sequences.
// Builds the header and parity, decodes ACK, retries WAIT and returns one response per command.
module swd_xfer_engine #(
  parameter int unsigned DIV_W       = 8,
  parameter int unsigned RETRY_W     = 4,
  parameter int unsigned IDLE_CYCLES = 2,
  parameter int unsigned LRST_LEN    = 56
) (
  input  logic               PHY_CLK,
  input  logic               RESETn,
  input  logic [DIV_W-1:0]   CFG_DIV,
  input  logic [1:0]         CFG_TRN,
  input  logic [RETRY_W-1:0] CFG_RETRY,
  input  logic               CMD_VALID,
  output logic               CMD_READY,
  input  logic               CMD_LRST,
  input  logic               CMD_APNDP,
  input  logic               CMD_RNW,
  input  logic [1:0]         CMD_ADDR,
  input  logic [31:0]        CMD_WDATA,
  output logic               RSP_VALID,
  input  logic               RSP_READY,
  output logic [2:0]         RSP_ACK,
  output logic [31:0]        RSP_RDATA,
  output logic               RSP_PERR,
  output logic [RETRY_W-1:0] RSP_RETRIES,
  output logic               SWDCLK,
  input  logic               SWDIN,
  output logic               SWDOUT,
  output logic               SWDOE
);

  localparam int unsigned MAX_A   = (LRST_LEN > 33) ? LRST_LEN : 33;
  localparam int unsigned BIT_MAX = (MAX_A > IDLE_CYCLES) ? MAX_A : IDLE_CYCLES;
  localparam int unsigned BIT_W   = $clog2(BIT_MAX + 1);
  localparam int unsigned POST_LAST = (IDLE_CYCLES == 0) ? 0 : IDLE_CYCLES - 1;
  localparam logic [2:0]  ACK_OK   = 3'b001;
  localparam logic [2:0]  ACK_WAIT = 3'b010;

  typedef enum logic [3:0] {
    S_IDLE, S_HDR, S_TRN1, S_ACK, S_RDATA, S_TRN2, S_WDATA, S_LRST, S_POST, S_RESP
  } state_t;

  localparam state_t POST_NEXT = (IDLE_CYCLES != 0) ? S_POST : S_RESP;

  state_t             state;
  logic [DIV_W-1:0]   div_q;
  logic [DIV_W-1:0]   phase_cnt;
  logic [1:0]         trn_q;
  logic [RETRY_W-1:0] retry_max_q;
  logic [RETRY_W-1:0] retry_cnt;
  logic               lrst_q, apndp_q, rnw_q;
  logic [1:0]         addr_q;
  logic [31:0]        wdata_q;
  logic [BIT_W-1:0]   bit_cnt;
  logic [2:0]         ack_sh;
  logic [31:0]        rdata_sh;
  logic               par_q;

  logic [7:0]         hdr_c;
  logic [BIT_W-1:0]   last_idx_c;
  state_t             nxt_state_c;
  logic [BIT_W-1:0]   nxt_bit_c;
  logic               retry_inc_c;
  logic               nxt_out_c, nxt_oe_c;
  logic               ok_rd_c;

  // Header as driven on the wire, index = bit position in time.
  assign hdr_c   = {1'b1, 1'b0, apndp_q ^ rnw_q ^ addr_q[0] ^ addr_q[1],
                    addr_q[1], addr_q[0], rnw_q, apndp_q, 1'b1};
  assign ok_rd_c = !lrst_q && (ack_sh == ACK_OK) && rnw_q;

  always_comb begin
    last_idx_c = '0;
    case (state)
      S_HDR:           last_idx_c = BIT_W'(7);
      S_TRN1, S_TRN2:  last_idx_c = BIT_W'(trn_q);
      S_ACK:           last_idx_c = BIT_W'(2);
      S_RDATA,S_WDATA: last_idx_c = BIT_W'(32);
      S_LRST:          last_idx_c = BIT_W'(LRST_LEN - 1);
      S_POST:          last_idx_c = BIT_W'(POST_LAST);
      default:         last_idx_c = '0;
    endcase
  end

  // Where the sequence goes once the current SWD bit has finished.
  always_comb begin
    nxt_state_c = state;
    nxt_bit_c   = bit_cnt + BIT_W'(1);
    retry_inc_c = 1'b0;
    if (bit_cnt == last_idx_c) begin
      nxt_bit_c = '0;
      case (state)
        S_HDR:   nxt_state_c = S_TRN1;
        S_TRN1:  nxt_state_c = S_ACK;
        S_ACK:   nxt_state_c = ((ack_sh == ACK_OK) && rnw_q) ? S_RDATA : S_TRN2;
        S_RDATA: nxt_state_c = S_TRN2;
        S_TRN2: begin
          if ((ack_sh == ACK_OK) && !rnw_q) begin
            nxt_state_c = S_WDATA;
          end else if ((ack_sh == ACK_WAIT) && (retry_cnt < retry_max_q)) begin
            nxt_state_c = S_HDR;
            retry_inc_c = 1'b1;
          end else begin
            nxt_state_c = POST_NEXT;
          end
        end
        S_WDATA, S_LRST: nxt_state_c = POST_NEXT;
        S_POST:          nxt_state_c = S_RESP;
        default:         nxt_state_c = state;
      endcase
    end
  end

  always_comb begin
    nxt_out_c = 1'b0;
    nxt_oe_c  = 1'b1;
    case (nxt_state_c)
      S_HDR:   nxt_out_c = hdr_c[nxt_bit_c[2:0]];
      S_TRN1, S_ACK, S_RDATA, S_TRN2: nxt_oe_c = 1'b0;
      S_WDATA: nxt_out_c = (nxt_bit_c == BIT_W'(32)) ? ^wdata_q : wdata_q[nxt_bit_c[4:0]];
      S_LRST:  nxt_out_c = 1'b1;
      default: nxt_out_c = 1'b0;
    endcase
  end

  always_ff @(posedge PHY_CLK) begin
    if (!RESETn) begin
      state       <= S_IDLE;
      SWDCLK      <= 1'b0;
      SWDOUT      <= 1'b0;
      SWDOE       <= 1'b1;
      CMD_READY   <= 1'b1;
      RSP_VALID   <= 1'b0;
      RSP_ACK     <= '0;
      RSP_RDATA   <= '0;
      RSP_PERR    <= 1'b0;
      RSP_RETRIES <= '0;
      retry_cnt   <= '0;
      div_q       <= '0;
      phase_cnt   <= '0;
      trn_q       <= '0;
      retry_max_q <= '0;
      lrst_q      <= 1'b0;
      apndp_q     <= 1'b0;
      rnw_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      bit_cnt     <= '0;
      ack_sh      <= '0;
      rdata_sh    <= '0;
      par_q       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (CMD_VALID && CMD_READY) begin
            div_q       <= CFG_DIV;
            trn_q       <= CFG_TRN;
            retry_max_q <= CFG_RETRY;
            lrst_q      <= CMD_LRST;
            apndp_q     <= CMD_APNDP;
            rnw_q       <= CMD_RNW;
            addr_q      <= CMD_ADDR;
            wdata_q     <= CMD_WDATA;
            retry_cnt   <= '0;
            bit_cnt     <= '0;
            phase_cnt   <= '0;
            CMD_READY   <= 1'b0;
            SWDCLK      <= 1'b0;
            SWDOUT      <= 1'b1;  // header start bit and line-reset ones are both 1
            SWDOE       <= 1'b1;
            state       <= CMD_LRST ? S_LRST : S_HDR;
          end
        end
        S_RESP: begin
          if (RSP_READY) begin
            RSP_VALID <= 1'b0;
            CMD_READY <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          if (phase_cnt != div_q) begin
            phase_cnt <= phase_cnt + DIV_W'(1);
          end else if (!SWDCLK) begin
            // Rising edge: target data is captured on this same PHY_CLK edge.
            phase_cnt <= '0;
            SWDCLK    <= 1'b1;
            if (state == S_ACK) ack_sh <= {SWDIN, ack_sh[2:1]};
            if (state == S_RDATA) begin
              if (bit_cnt == BIT_W'(32)) par_q <= SWDIN;
              else                       rdata_sh <= {SWDIN, rdata_sh[31:1]};
            end
          end else begin
            phase_cnt <= '0;
            SWDCLK    <= 1'b0;
            state     <= nxt_state_c;
            bit_cnt   <= nxt_bit_c;
            SWDOUT    <= nxt_out_c;
            SWDOE     <= nxt_oe_c;
            if (retry_inc_c) retry_cnt <= retry_cnt + RETRY_W'(1);
            if (nxt_state_c == S_RESP) begin
              RSP_VALID   <= 1'b1;
              RSP_ACK     <= lrst_q ? ACK_OK : ack_sh;
              RSP_RDATA   <= ok_rd_c ? rdata_sh : 32'h0;
              RSP_PERR    <= ok_rd_c && (par_q != ^rdata_sh);
              RSP_RETRIES <= lrst_q ? '0 : retry_cnt;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_swd_xfer_engine.sv
// Bench for swd_xfer_engine: a wire-level bit list model plus an emulated target.
`timescale 1ns/1ps
module tb_swd_xfer_engine;

  localparam int unsigned DIV_W       = 8;
  localparam int unsigned RETRY_W     = 4;
  localparam int unsigned IDLE_CYCLES = 2;
  localparam int unsigned LRST_LEN    = 56;

  logic               PHY_CLK = 1'b0;
  logic               RESETn = 1'b0;
  logic [DIV_W-1:0]   CFG_DIV = '0;
  logic [1:0]         CFG_TRN = '0;
  logic [RETRY_W-1:0] CFG_RETRY = '0;
  logic               CMD_VALID = 1'b0;
  logic               CMD_READY;
  logic               CMD_LRST = 1'b0;
  logic               CMD_APNDP = 1'b0;
  logic               CMD_RNW = 1'b0;
  logic [1:0]         CMD_ADDR = '0;
  logic [31:0]        CMD_WDATA = '0;
  logic               RSP_VALID;
  logic               RSP_READY = 1'b0;
  logic [2:0]         RSP_ACK;
  logic [31:0]        RSP_RDATA;
  logic               RSP_PERR;
  logic [RETRY_W-1:0] RSP_RETRIES;
  logic               SWDCLK;
  logic               SWDIN = 1'b0;
  logic               SWDOUT;
  logic               SWDOE;

  swd_xfer_engine #(.DIV_W(DIV_W), .RETRY_W(RETRY_W), .IDLE_CYCLES(IDLE_CYCLES),
                    .LRST_LEN(LRST_LEN)) dut (
    .PHY_CLK(PHY_CLK), .RESETn(RESETn), .CFG_DIV(CFG_DIV), .CFG_TRN(CFG_TRN),
    .CFG_RETRY(CFG_RETRY), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_LRST(CMD_LRST), .CMD_APNDP(CMD_APNDP), .CMD_RNW(CMD_RNW), .CMD_ADDR(CMD_ADDR),
    .CMD_WDATA(CMD_WDATA), .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
    .RSP_ACK(RSP_ACK), .RSP_RDATA(RSP_RDATA), .RSP_PERR(RSP_PERR),
    .RSP_RETRIES(RSP_RETRIES), .SWDCLK(SWDCLK), .SWDIN(SWDIN), .SWDOUT(SWDOUT),
    .SWDOE(SWDOE)
  );

  always #5 PHY_CLK = ~PHY_CLK;

  typedef struct packed { logic oe; logic out; logic din; } sbit_t;

  sbit_t       bits[$];
  logic        wire_bits[$];
  int          vectors = 0;
  int          errors  = 0;
  int          rises   = 0;
  logic        clk_prev = 1'b0;
  int          attempts;
  logic [2:0]  acks[16];
  logic [2:0]  exp_ack;
  logic [31:0] exp_rdata;
  logic        exp_perr;
  int          exp_ret;
  logic [2:0]  got_ack;
  logic [31:0] got_rdata;
  logic        got_perr;
  int          got_ret;

  always @(negedge PHY_CLK) begin
    if (SWDCLK && !clk_prev) rises++;
    clk_prev = SWDCLK;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void push_host(input logic v);
    bits.push_back('{oe: 1'b1, out: v, din: 1'($urandom)});
  endfunction

  function automatic void push_tgt(input logic v);
    bits.push_back('{oe: 1'b0, out: 1'b0, din: v});
  endfunction

  // Wire-level expectation of one command, written straight from the protocol rules.
  task automatic build_model(input logic lrst, input logic apndp, input logic rnw,
                             input logic [1:0] addr, input logic [31:0] wd, input int trn,
                             input int rmax, input logic [31:0] rd, input logic rpar);
    logic [2:0] ack;
    bit done;
    bits.delete();
    attempts = 0; exp_ret = 0; done = 0;
    exp_ack = 3'b001; exp_rdata = '0; exp_perr = 1'b0;
    if (lrst) begin
      for (int i = 0; i < LRST_LEN; i++) push_host(1'b1);
    end else begin
      while (!done) begin
        attempts++;
        push_host(1'b1); push_host(apndp); push_host(rnw); push_host(addr[0]);
        push_host(addr[1]); push_host(apndp ^ rnw ^ addr[0] ^ addr[1]);
        push_host(1'b0); push_host(1'b1);
        for (int i = 0; i <= trn; i++) push_tgt(1'($urandom));
        ack = acks[attempts-1];
        for (int i = 0; i < 3; i++) push_tgt(ack[i]);
        if (ack == 3'b001 && rnw) begin
          for (int i = 0; i < 32; i++) push_tgt(rd[i]);
          push_tgt(rpar);
        end
        for (int i = 0; i <= trn; i++) push_tgt(1'($urandom));
        if (ack == 3'b001 && !rnw) begin
          for (int i = 0; i < 32; i++) push_host(wd[i]);
          push_host(^wd);
        end
        if (ack == 3'b010 && exp_ret < rmax) begin
          exp_ret++;
        end else begin
          done = 1;
          exp_ack = ack;
          if (ack == 3'b001 && rnw) begin
            exp_rdata = rd;
            exp_perr  = (rpar != ^rd);
          end
        end
      end
    end
    for (int i = 0; i < int'(IDLE_CYCLES); i++) push_host(1'b0);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_swdclk"}, 32'(SWDCLK), 32'd0);
    chk({tag, "_swdoe"}, 32'(SWDOE), 32'd1);
    chk({tag, "_swdout"}, 32'(SWDOUT), 32'd0);
    chk({tag, "_cmd_ready"}, 32'(CMD_READY), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(RSP_VALID), 32'd0);
  endtask

  task automatic check_resp();
    chk("rsp_valid", 32'(RSP_VALID), 32'd1);
    chk("rsp_ack", 32'(RSP_ACK), 32'(exp_ack));
    chk("rsp_rdata", RSP_RDATA, exp_rdata);
    chk("rsp_perr", 32'(RSP_PERR), 32'(exp_perr));
    chk("rsp_retries", 32'(RSP_RETRIES), 32'(exp_ret));
    chk("resp_swdclk", 32'(SWDCLK), 32'd0);
    chk("resp_cmd_ready", 32'(CMD_READY), 32'd0);
  endtask

  // Starts just after a posedge; returns just after a posedge.
  task automatic run_xfer(input logic lrst, input logic apndp, input logic rnw,
                          input logic [1:0] addr, input logic [31:0] wd, input int div,
                          input int trn, input int rmax, input logic [31:0] rd,
                          input logic rpar, input int abort_at);
    int p, n, hold;
    sbit_t b;
    build_model(lrst, apndp, rnw, addr, wd, trn, rmax, rd, rpar);
    p = 2 * (div + 1);
    n = bits.size() * p;
    wire_bits.delete();
    CMD_VALID = 1'b1; CMD_LRST = lrst; CMD_APNDP = apndp; CMD_RNW = rnw;
    CMD_ADDR = addr; CMD_WDATA = wd;
    CFG_DIV = DIV_W'(div); CFG_TRN = 2'(trn); CFG_RETRY = RETRY_W'(rmax);
    @(negedge PHY_CLK);
    chk("cmd_ready", 32'(CMD_READY), 32'd1);
    @(posedge PHY_CLK); #1;
    CMD_VALID = 1'b0;
    CFG_DIV = DIV_W'($urandom); CFG_TRN = 2'($urandom); CFG_RETRY = RETRY_W'($urandom);
    CMD_WDATA = $urandom; CMD_RNW = 1'($urandom); CMD_ADDR = 2'($urandom);
    CMD_APNDP = 1'($urandom); CMD_LRST = 1'($urandom);
    for (int i = 0; i < n; i++) begin
      b = bits[i / p];
      SWDIN = b.din;
      @(negedge PHY_CLK);
      chk("swdclk", 32'(SWDCLK), 32'((i % p) >= (div + 1)));
      chk("swdoe", 32'(SWDOE), 32'(b.oe));
      if (b.oe) chk("swdout", 32'(SWDOUT), 32'(b.out));
      chk("busy_flags", 32'({CMD_READY, RSP_VALID}), 32'd0);
      if (i % p == 0) wire_bits.push_back(SWDOUT);
      if (i == abort_at) begin
        RESETn = 1'b0;
        @(posedge PHY_CLK); #1;
        RESETn = 1'b1;
        @(negedge PHY_CLK);
        check_idle("abort");
        chk("abort_rsp_ack", 32'(RSP_ACK), 32'd0);
        @(posedge PHY_CLK); #1;
        return;
      end
      @(posedge PHY_CLK); #1;
    end
    hold = $urandom_range(0, 3);
    for (int h = 0; h <= hold; h++) begin
      @(negedge PHY_CLK);
      check_resp();
      if (h == 0) begin
        got_ack = RSP_ACK; got_rdata = RSP_RDATA; got_perr = RSP_PERR;
        got_ret = int'(RSP_RETRIES);
      end
      @(posedge PHY_CLK); #1;
    end
    RSP_READY = 1'b1;
    @(negedge PHY_CLK);
    check_resp();
    @(posedge PHY_CLK); #1;
    RSP_READY = 1'b0;
    @(negedge PHY_CLK);
    check_idle("post_resp");
    @(posedge PHY_CLK); #1;
  endtask

  function automatic logic [31:0] wire_word(input int start, input int len);
    logic [31:0] v = '0;
    for (int i = 0; i < len; i++) v[i] = wire_bits[start + i];
    return v;
  endfunction

  initial begin
    int r0, ones;
    logic [31:0] rd;
    logic rp, lr;
    for (int i = 0; i < 16; i++) acks[i] = 3'b001;
    repeat (3) @(posedge PHY_CLK);
    #1;
    @(negedge PHY_CLK);
    check_idle("reset");
    chk("reset_rsp", 32'({RSP_ACK, RSP_PERR, RSP_RETRIES}), 32'd0);
    chk("reset_rdata", RSP_RDATA, 32'd0);
    @(posedge PHY_CLK); #1;
    RESETn = 1'b1;

    // DP read, OK, known IDCODE-style data.
    r0 = rises;
    run_xfer(0, 0, 1, 2'd0, 32'h0, 0, 0, 0, 32'h2BA01477, 1'b0, -1);
    chk("t1_model_bits", 32'(bits.size()), 32'd48);
    chk("t1_rises", 32'(rises - r0), 32'd48);
    chk("t1_header", wire_word(0, 8), 32'hA5);
    chk("t1_ack", 32'(got_ack), 32'd1);
    chk("t1_rdata", got_rdata, 32'h2BA01477);
    chk("t1_perr", 32'(got_perr), 32'd0);

    // AP write, OK.
    run_xfer(0, 1, 0, 2'd1, 32'h23000002, 0, 0, 0, 32'h0, 1'b0, -1);
    chk("t2_header", wire_word(0, 8), 32'h8B);
    chk("t2_wdata", wire_word(13, 32), 32'h23000002);
    chk("t2_wpar", 32'(wire_bits[45]), 32'd0);

    // WAIT, WAIT, OK with room for three attempts, then with only one retry.
    acks[0] = 3'b010; acks[1] = 3'b010; acks[2] = 3'b001;
    run_xfer(0, 0, 1, 2'd2, 32'h0, 1, 1, 3, 32'hDEADBEEF, ^32'hDEADBEEF, -1);
    chk("t3_attempts", 32'(attempts), 32'd3);
    chk("t3_retries", 32'(got_ret), 32'd2);
    chk("t3_ack", 32'(got_ack), 32'd1);
    run_xfer(0, 0, 1, 2'd2, 32'h0, 1, 1, 1, 32'hDEADBEEF, ^32'hDEADBEEF, -1);
    chk("t3b_attempts", 32'(attempts), 32'd2);
    chk("t3b_retries", 32'(got_ret), 32'd1);
    chk("t3b_ack", 32'(got_ack), 32'd2);
    chk("t3b_rdata", got_rdata, 32'd0);
    acks[0] = 3'b001; acks[1] = 3'b001;

    // Read parity error.
    run_xfer(0, 1, 1, 2'd3, 32'h0, 0, 2, 0, 32'h00000001, 1'b0, -1);
    chk("t4_perr", 32'(got_perr), 32'd1);
    chk("t4_rdata", got_rdata, 32'h00000001);

    // Line reset with a slow clock.
    r0 = rises;
    run_xfer(1, 0, 0, 2'd0, 32'h0, 3, 0, 0, 32'h0, 1'b0, -1);
    ones = 0;
    for (int i = 0; i < 56; i++) ones += int'(wire_bits[i]);
    chk("t5_ones", 32'(ones), 32'd56);
    chk("t5_tail", 32'({wire_bits[56], wire_bits[57]}), 32'd0);
    chk("t5_rises", 32'(rises - r0), 32'd58);
    chk("t5_ack", 32'(got_ack), 32'd1);

    // Reset in the middle of read data, then a normal command.
    run_xfer(0, 0, 1, 2'd0, 32'h0, 0, 0, 0, 32'h12345678, ^32'h12345678, 40);
    run_xfer(0, 1, 0, 2'd2, 32'hCAFEF00D, 1, 0, 0, 32'h0, 1'b0, -1);

    // Randomized commands, configs and target behaviour.
    for (int t = 0; t < 24; t++) begin
      for (int j = 0; j < 16; j++) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4: acks[j] = 3'b001;
          5, 6, 7:       acks[j] = 3'b010;
          8:             acks[j] = 3'b100;
          default:       acks[j] = 3'b111;
        endcase
      end
      rd = $urandom;
      rp = ($urandom_range(0, 4) == 0) ? ~(^rd) : ^rd;
      lr = ($urandom_range(0, 7) == 0);
      run_xfer(lr, 1'($urandom), 1'($urandom), 2'($urandom), $urandom,
               $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 3),
               rd, rp, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
